// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Macro DMEM_ARB_RR_EN selects round-robin arbitration (default: fixed priority, port 0 wins).
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select between the two requesters.
// Macro DMEM_ARB_RR_EN: defined = round-robin on last-served pointer, undefined = port 0 priority.
module dmem_arb_pick
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
`ifdef DMEM_ARB_RR_EN
  input  logic       last_i,
`endif
  output logic       win_o
);

  always_comb begin
    win_o = P0;
`ifdef DMEM_ARB_RR_EN
    case (req_i)
      2'b11:   win_o = ~last_i;
      2'b10:   win_o = P1;
      default: win_o = P0;
    endcase
`else
    if (req_i == 2'b10) win_o = P1;
`endif
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port sequencer/arbiter for a single-ported synchronous-read data memory.
// Macro DMEM_ARB_RR_EN enables round-robin arbitration; otherwise port 0 has fixed priority.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [3:0]        p0_be,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [31:0]       p0_wdata,
  output logic              p0_gnt,
  output logic              p0_done,
  output logic [31:0]       p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [3:0]        p1_be,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [31:0]       p1_wdata,
  output logic              p1_gnt,
  output logic              p1_done,
  output logic [31:0]       p1_rdata,
  output logic [ADDR_W-1:0] daddr,
  output logic [31:0]       dwdata,
  output logic [3:0]        we_dmem,
  output logic              dre,
  input  logic [31:0]       drdata
);

  state_e            state_q, state_d;
  logic              cap_we_q, cap_we_d;
  logic [3:0]        cap_be_q, cap_be_d;
  logic [ADDR_W-1:0] cap_addr_q, cap_addr_d;
  logic [31:0]       cap_wdata_q, cap_wdata_d;
  logic              cap_owner_q, cap_owner_d;
  logic              win;
  logic              start;
  logic              access;
  logic              resp;

`ifdef DMEM_ARB_RR_EN
  logic last_q, last_d;

  dmem_arb_pick u_pick (
    .req_i  ({p1_req, p0_req}),
    .last_i (last_q),
    .win_o  (win)
  );

  assign last_d = start ? win : last_q;

  always_ff @(posedge clk) begin
    if (rst) last_q <= P1;
    else     last_q <= last_d;
  end
`else
  dmem_arb_pick u_pick (
    .req_i (({p1_req, p0_req})),
    .win_o (win)
  );
`endif

  always_comb begin
    state_d     = state_q;
    start       = 1'b0;
    cap_we_d    = cap_we_q;
    cap_be_d    = cap_be_q;
    cap_addr_d  = cap_addr_q;
    cap_wdata_d = cap_wdata_q;
    cap_owner_d = cap_owner_q;
    case (state_q)
      StIdle: begin
        // A grant during reset would be accepted by the requester yet dropped here.
        if ((p0_req || p1_req) && !rst) begin
          start       = 1'b1;
          state_d     = StAccess;
          cap_owner_d = win;
          cap_we_d    = (win == P1) ? p1_we    : p0_we;
          cap_be_d    = (win == P1) ? p1_be    : p0_be;
          cap_addr_d  = (win == P1) ? p1_addr  : p0_addr;
          cap_wdata_d = (win == P1) ? p1_wdata : p0_wdata;
        end
      end
      StAccess: state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cap_we_q    <= 1'b0;
      cap_be_q    <= 4'b0;
      cap_addr_q  <= '0;
      cap_wdata_q <= 32'b0;
      cap_owner_q <= P0;
    end else begin
      state_q     <= state_d;
      cap_we_q    <= cap_we_d;
      cap_be_q    <= cap_be_d;
      cap_addr_q  <= cap_addr_d;
      cap_wdata_q <= cap_wdata_d;
      cap_owner_q <= cap_owner_d;
    end
  end

  always_comb begin
    access   = (state_q == StAccess);
    resp     = (state_q == StResp);
    p0_gnt   = start && (win == P0);
    p1_gnt   = start && (win == P1);
    daddr    = cap_addr_q;
    dwdata   = cap_wdata_q;
    we_dmem  = (access && cap_we_q) ? cap_be_q : 4'b0;
    dre      = access && !cap_we_q;
    p0_done  = resp && (cap_owner_q == P0);
    p1_done  = resp && (cap_owner_q == P1);
    p0_rdata = (p0_done && !cap_we_q) ? drdata : 32'b0;
    p1_rdata = (p1_done && !cap_we_q) ? drdata : 32'b0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized run
// against a transaction-level model. Honours DMEM_ARB_RR_EN for arbitration expectations.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [3:0]  p0_be, p1_be;
  logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
  logic        p0_gnt, p0_done, p1_gnt, p1_done;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] daddr, dwdata;
  logic [3:0]  we_dmem;
  logic        dre;
  logic [31:0] drdata = 32'b0;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];

  dmem_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_be(p0_be), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_be(p1_be), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
    .daddr(daddr), .dwdata(dwdata), .we_dmem(we_dmem), .dre(dre), .drdata(drdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read, byte-writable memory seen by the DUT.
  always @(posedge clk) begin
    if (dre) drdata <= mem[daddr[9:2]];
    for (int b = 0; b < 4; b++)
      if (we_dmem[b]) mem[daddr[9:2]][b*8 +: 8] <= dwdata[b*8 +: 8];
  end

  task automatic idle_inputs();
    p0_req = 0; p0_we = 0; p0_be = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_be = 0; p1_addr = 0; p1_wdata = 0;
  endtask

  task automatic init_mems();
    for (int i = 0; i < 256; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
  endtask

  // Leaves the bench at a negedge with rst low and the DUT freshly reset.
  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    idle_inputs();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    #2;
    tests++;
    if ({p0_gnt, p1_gnt, p0_done, p1_done, we_dmem, dre} !== 9'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b required 0", {p0_gnt, p1_gnt, p0_done, p1_done, we_dmem, dre});
    end
    tests++;
    if (daddr !== 32'b0 || dwdata !== 32'b0) begin
      fails++;
      $display("FAIL reset_mem_bus: daddr=%h dwdata=%h required 0", daddr, dwdata);
    end
    tests++;
    if (p0_rdata !== 32'b0 || p1_rdata !== 32'b0) begin
      fails++;
      $display("FAIL reset_rdata: p0=%h p1=%h required 0", p0_rdata, p1_rdata);
    end
  endtask

  task automatic test_single_read();
    mem[16] = 32'hDEADBEEF;
    @(negedge clk);
    p0_req = 1; p0_we = 0; p0_addr = 32'h40;
    #2;
    tests++;
    if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin
      fails++;
      $display("FAIL read_gnt: p0_gnt=%b p1_gnt=%b required 1/0", p0_gnt, p1_gnt);
    end
    @(negedge clk);
    p0_req = 0;
    #2;
    tests++;
    if (dre !== 1'b1 || daddr !== 32'h40 || we_dmem !== 4'b0 || p0_done !== 1'b0) begin
      fails++;
      $display("FAIL read_access: dre=%b daddr=%h we=%b done=%b required 1/40/0000/0",
               dre, daddr, we_dmem, p0_done);
    end
    @(negedge clk);
    #2;
    tests++;
    if (p0_done !== 1'b1 || p0_rdata !== 32'hDEADBEEF || p1_done !== 1'b0 || dre !== 1'b0) begin
      fails++;
      $display("FAIL read_resp: done=%b rdata=%h p1_done=%b dre=%b required 1/deadbeef/0/0",
               p0_done, p0_rdata, p1_done, dre);
    end
    @(negedge clk);
    #2;
    tests++;
    if (p0_done !== 1'b0 || p0_rdata !== 32'b0) begin
      fails++;
      $display("FAIL read_after: done=%b rdata=%h required 0/0", p0_done, p0_rdata);
    end
  endtask

  task automatic test_byte_write();
    mem[17] = 32'h11223344;
    @(negedge clk);
    p1_req = 1; p1_we = 1; p1_be = 4'b0100; p1_addr = 32'h44; p1_wdata = 32'h00AA0000;
    #2;
    tests++;
    if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0 || we_dmem !== 4'b0) begin
      fails++;
      $display("FAIL write_gnt: p1_gnt=%b p0_gnt=%b we=%b required 1/0/0000", p1_gnt, p0_gnt, we_dmem);
    end
    @(negedge clk);
    idle_inputs();
    #2;
    tests++;
    if (we_dmem !== 4'b0100 || dre !== 1'b0 || daddr !== 32'h44 || dwdata !== 32'h00AA0000) begin
      fails++;
      $display("FAIL write_access: we=%b dre=%b daddr=%h dwdata=%h required 0100/0/44/00aa0000",
               we_dmem, dre, daddr, dwdata);
    end
    @(negedge clk);
    #2;
    tests++;
    if (p1_done !== 1'b1 || p0_done !== 1'b0 || we_dmem !== 4'b0 || p1_rdata !== 32'b0) begin
      fails++;
      $display("FAIL write_resp: p1_done=%b p0_done=%b we=%b rdata=%h required 1/0/0000/0",
               p1_done, p0_done, we_dmem, p1_rdata);
    end
    @(negedge clk);
    p1_req = 1; p1_we = 0; p1_addr = 32'h44;
    #2;
    tests++;
    if (p1_gnt !== 1'b1) begin
      fails++;
      $display("FAIL readback_gnt: p1_gnt=%b required 1", p1_gnt);
    end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    #2;
    tests++;
    if (p1_done !== 1'b1 || p1_rdata !== 32'h11AA3344) begin
      fails++;
      $display("FAIL readback_data: done=%b rdata=%h required 1/11aa3344", p1_done, p1_rdata);
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp;
    do_reset();
    p0_req = 1; p0_we = 0; p0_addr = 32'h0;
    p1_req = 1; p1_we = 0; p1_addr = 32'h4;
    for (int i = 0; i < 12; i++) begin
      if (i != 0) @(negedge clk);
      #2;
      exp = 2'b00;
      if (i % 3 == 0) begin
`ifdef DMEM_ARB_RR_EN
        exp = ((i / 3) % 2 == 1) ? 2'b10 : 2'b01;
`else
        exp = 2'b01;
`endif
      end
      tests++;
      if ({p1_gnt, p0_gnt} !== exp) begin
        fails++;
        $display("FAIL contention_c%0d: gnt{p1,p0}=%b required %b", i, {p1_gnt, p0_gnt}, exp);
      end
    end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    p0_req = 1; p0_we = 1; p0_be = 4'hF; p0_addr = 32'h80; p0_wdata = 32'h55AA55AA;
    #2;
    tests++;
    if (p0_gnt !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_gnt: p0_gnt=%b required 1", p0_gnt);
    end
    @(negedge clk);
    idle_inputs();
    rst = 1;
    #2;
    tests++;
    if (we_dmem !== 4'hF) begin
      fails++;
      $display("FAIL rstmid_access: we=%b required 1111", we_dmem);
    end
    @(negedge clk);
    rst = 0;
    #2;
    tests++;
    if ({p0_gnt, p1_gnt, p0_done, p1_done, we_dmem, dre} !== 9'b0 || daddr !== 32'b0 ||
        dwdata !== 32'b0 || p0_rdata !== 32'b0 || p1_rdata !== 32'b0) begin
      fails++;
      $display("FAIL rstmid_outputs: ctrl=%b daddr=%h dwdata=%h required all 0",
               {p0_gnt, p1_gnt, p0_done, p1_done, we_dmem, dre}, daddr, dwdata);
    end
    @(negedge clk);
    p0_req = 1; p0_we = 0; p0_addr = 32'h40;
    #2;
    tests++;
    if (p0_gnt !== 1'b1 || p0_done !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_newgnt: gnt=%b done=%b required 1/0", p0_gnt, p0_done);
    end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    #2;
    tests++;
    if (p0_done !== 1'b1 || p0_rdata !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL rstmid_newdone: done=%b rdata=%h required 1/deadbeef", p0_done, p0_rdata);
    end
  endtask

  task automatic test_withdraw();
    @(negedge clk);
    p0_req = 1; p0_we = 0; p0_addr = 32'h40;
    #2;
    tests++;
    if (p0_gnt !== 1'b1) begin
      fails++;
      $display("FAIL withdraw_p0gnt: p0_gnt=%b required 1", p0_gnt);
    end
    @(negedge clk);
    p0_req = 0;
    p1_req = 1; p1_we = 1; p1_be = 4'hF; p1_addr = 32'h40; p1_wdata = 32'h12345678;
    #2;
    tests++;
    if (p1_gnt !== 1'b0 || p0_gnt !== 1'b0 || dre !== 1'b1) begin
      fails++;
      $display("FAIL withdraw_access: p1_gnt=%b p0_gnt=%b dre=%b required 0/0/1", p1_gnt, p0_gnt, dre);
    end
    @(negedge clk);
    idle_inputs();
    #2;
    tests++;
    if (p0_done !== 1'b1 || p0_rdata !== 32'hDEADBEEF || p1_done !== 1'b0 || p1_gnt !== 1'b0) begin
      fails++;
      $display("FAIL withdraw_resp: p0_done=%b rdata=%h p1_done=%b p1_gnt=%b required 1/deadbeef/0/0",
               p0_done, p0_rdata, p1_done, p1_gnt);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #2;
      tests++;
      if (p1_done !== 1'b0 || p1_gnt !== 1'b0 || we_dmem !== 4'b0 || dre !== 1'b0) begin
        fails++;
        $display("FAIL withdraw_quiet%0d: p1_done=%b p1_gnt=%b we=%b dre=%b required 0",
                 i, p1_done, p1_gnt, we_dmem, dre);
      end
    end
  endtask

  // Transaction-level model: each accepted request occupies three cycles
  // (grant, memory access, completion); reads return the word as of the access.
  task automatic test_random();
    logic [1:0]  act;
    logic [1:0]  rwe;
    logic [3:0]  rbe   [2];
    logic [31:0] raddr [2];
    logic [31:0] rwd   [2];
    int          phase;
    logic        w, own, last, mwe;
    logic [3:0]  mbe;
    logic [31:0] maddr, mwd, mrd;
    logic [1:0]  exp_gnt, exp_done;
    logic [3:0]  exp_we;
    logic        exp_dre;
    logic [31:0] exp_rd0, exp_rd1;

    init_mems();
    do_reset();
    act = 0; rwe = 0; phase = 0; w = 0; own = 0; last = 1; mwe = 0;
    mbe = 0; maddr = 0; mwd = 0; mrd = 0;
    for (int p = 0; p < 2; p++) begin
      rbe[p] = 0; raddr[p] = 0; rwd[p] = 0;
    end
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (cyc != 0) @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (!act[p] && $urandom_range(0, 1) == 1) begin
          act[p]   = 1'b1;
          rwe[p]   = 1'($urandom_range(0, 1));
          rbe[p]   = 4'($urandom);
          raddr[p] = 32'($urandom_range(0, 63)) << 2;
          rwd[p]   = $urandom;
        end
      end
      p0_req = act[0]; p0_we = rwe[0]; p0_be = rbe[0]; p0_addr = raddr[0]; p0_wdata = rwd[0];
      p1_req = act[1]; p1_we = rwe[1]; p1_be = rbe[1]; p1_addr = raddr[1]; p1_wdata = rwd[1];

      exp_gnt = 2'b00;
      if (phase == 0 && act != 2'b00) begin
`ifdef DMEM_ARB_RR_EN
        w = (act == 2'b11) ? ~last : act[1] && !act[0];
`else
        w = (act == 2'b10);
`endif
        exp_gnt = w ? 2'b10 : 2'b01;
      end
      exp_we   = (phase == 1 && mwe) ? mbe : 4'b0;
      exp_dre  = (phase == 1 && !mwe);
      exp_done = (phase == 2) ? (own ? 2'b10 : 2'b01) : 2'b00;
      exp_rd0  = (phase == 2 && !own && !mwe) ? mrd : 32'b0;
      exp_rd1  = (phase == 2 && own && !mwe) ? mrd : 32'b0;

      #2;
      tests++;
      if ({p1_gnt, p0_gnt} !== exp_gnt) begin
        fails++;
        $display("FAIL rand_gnt c%0d: got %b required %b", cyc, {p1_gnt, p0_gnt}, exp_gnt);
      end
      tests++;
      if (we_dmem !== exp_we || dre !== exp_dre) begin
        fails++;
        $display("FAIL rand_mem c%0d: we=%b dre=%b required %b/%b", cyc, we_dmem, dre, exp_we, exp_dre);
      end
      tests++;
      if ({p1_done, p0_done} !== exp_done) begin
        fails++;
        $display("FAIL rand_done c%0d: got %b required %b", cyc, {p1_done, p0_done}, exp_done);
      end
      tests++;
      if (p0_rdata !== exp_rd0 || p1_rdata !== exp_rd1) begin
        fails++;
        $display("FAIL rand_rdata c%0d: p0=%h p1=%h required %h/%h", cyc, p0_rdata, p1_rdata,
                 exp_rd0, exp_rd1);
      end
      if (phase == 1) begin
        tests++;
        if (daddr !== maddr || (mwe && dwdata !== mwd)) begin
          fails++;
          $display("FAIL rand_bus c%0d: daddr=%h dwdata=%h required %h/%h", cyc, daddr, dwdata,
                   maddr, mwd);
        end
      end

      case (phase)
        0: if (exp_gnt != 2'b00) begin
          own = w; last = w; mwe = rwe[w]; mbe = rbe[w]; maddr = raddr[w]; mwd = rwd[w];
          act[w] = 1'b0;
          phase = 1;
        end
        1: begin
          if (mwe) begin
            for (int b = 0; b < 4; b++)
              if (mbe[b]) ref_mem[maddr[9:2]][b*8 +: 8] = mwd[b*8 +: 8];
          end else begin
            mrd = ref_mem[maddr[9:2]];
          end
          phase = 2;
        end
        default: phase = 0;
      endcase
    end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    init_mems();
    test_reset();
    test_single_read();
    test_byte_write();
    test_contention();
    test_reset_mid();
    test_withdraw();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
